// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared definitions for the bit-serial subtractor.
//               - SUB_WIDTH   : default operand/result width
//               - sub_state_t : controller states (IDLE, RUN, DONE)
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

   localparam int SUB_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_sub_slice.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_slice
// Description : One-bit subtract cell, s/cout = a_bit + ~b_bit + cin.
//               Purely combinational; the only arithmetic in the datapath.
// Ports       : a_bit - minuend bit
//               b_bit - subtrahend bit (inverted internally)
//               cin   - carry in
//               s     - sum bit
//               cout  - carry out (majority of the three addends)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_slice (
   input  logic a_bit,
   input  logic b_bit,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_nb;

   assign w_nb = ~b_bit;
   assign s    = a_bit ^ w_nb ^ cin;
   assign cout = (a_bit & w_nb) | (a_bit & cin) | (w_nb & cin);

endmodule
`default_nettype wire

// File: rtl/serial_sub_8bit.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_8bit
// Description : Bit-serial signed subtractor, diff = a - b, computed LSB first
//               as a + ~b + 1 over WIDTH cycles with a single carry flop.
//               Operands and results move through valid/ready handshakes.
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               in_valid  - operand pair a/b valid
//               in_ready  - idle, operands accepted
//               a, b      - signed minuend / subtrahend
//               out_valid - diff/ovf/uvf valid
//               out_ready - downstream accepts the result
//               diff      - a - b modulo 2^WIDTH
//               ovf / uvf - positive / negative overflow
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_8bit
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             ovf,
   output logic             uvf
);

   localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

   sub_state_t       r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic             r_ovf;
   logic             r_uvf;
   logic             r_sa;
   logic             r_sb;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_s;
   logic             w_cout;
   logic [WIDTH-1:0] w_res_next;

   serial_sub_slice u_slice (
      .a_bit (r_a_sr[0]),
      .b_bit (r_b_sr[0]),
      .cin   (r_carry),
      .s     (w_s),
      .cout  (w_cout)
   );

   // New bit enters at the MSB so after WIDTH shifts the LSB sits at bit 0.
   assign w_res_next = {w_s, r_res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_res   <= '0;
         r_diff  <= '0;
         r_ovf   <= 1'b0;
         r_uvf   <= 1'b0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_sa    <= a[WIDTH-1];
                  r_sb    <= b[WIDTH-1];
                  // Carry-in of 1 completes the two's-complement negation of b.
                  r_carry <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_carry <= w_cout;
               r_res   <= w_res_next;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == C_LAST) begin
                  // w_s is the result sign bit; final carry-out is discarded.
                  r_diff  <= w_res_next;
                  r_ovf   <= ~r_sa & r_sb & w_s;
                  r_uvf   <= r_sa & ~r_sb & ~w_s;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign diff      = r_diff;
   assign ovf       = r_ovf;
   assign uvf       = r_uvf;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub_8bit
// Description : Self-checking bench for serial_sub_8bit (WIDTH = 8).
//               Directed cases, random pairs against an integer-arithmetic
//               reference, backpressure and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_8bit;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         ovf;
   logic         uvf;

   int n_assert = 0;
   int n_fail   = 0;

   serial_sub_8bit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .ovf       (ovf),
      .uvf       (uvf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: true signed difference, wrapped result and range flags.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                        output logic [W-1:0] md, output logic mo, output logic mu);
      int ta;
      int tb;
      int td;
      ta = int'($signed(ma));
      tb = int'($signed(mb));
      td = ta - tb;
      md = W'(td);
      mo = (td > 127);
      mu = (td < -128);
   endtask

   // Present one operand pair and confirm it is taken on the next edge.
   task automatic start_op(input logic [W-1:0] sa, input logic [W-1:0] sb);
      @(negedge clk);
      check("ready_before_accept", 32'(in_ready), 32'd1);
      a        = sa;
      b        = sb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("ready_after_accept", 32'(in_ready), 32'd0);
      check("valid_after_accept", 32'(out_valid), 32'd0);
   endtask

   // Count edges after the accepting edge until out_valid; bounded.
   task automatic wait_done(input bit chk_ready, output int lat);
      lat = 0;
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) break;
         if (chk_ready) check("ready_low_in_run", 32'(in_ready), 32'd0);
      end
      check("latency", 32'(lat), 32'(W));
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] ca, input logic [W-1:0] cb);
      logic [W-1:0] ed;
      logic         eo;
      logic         eu;
      model(ca, cb, ed, eo, eu);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_diff"},  32'(diff), 32'(ed));
      check({tag, "_ovf"},   32'(ovf), 32'(eo));
      check({tag, "_uvf"},   32'(uvf), 32'(eu));
   endtask

   // Drain the result: out_valid must fall on the next edge.
   task automatic release_result();
      logic keep;
      keep = out_ready;
      if (!out_ready) begin
         @(negedge clk);
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check("valid_drops", 32'(out_valid), 32'd0);
      check("ready_returns", 32'(in_ready), 32'd1);
      out_ready = keep;
   endtask

   task automatic full_op(input string tag, input logic [W-1:0] fa, input logic [W-1:0] fb,
                          input bit chk_ready);
      int lat;
      start_op(fa, fb);
      wait_done(chk_ready, lat);
      check_result(tag, fa, fb);
      release_result();
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] held_d;
      logic         held_o;
      logic         held_u;
      int           lat;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #1;
      check("rst_in_ready",  32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff",      32'(diff), 32'd0);
      check("rst_ovf",       32'(ovf), 32'd0);
      check("rst_uvf",       32'(uvf), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      full_op("basic",   8'd5,    8'd3,    1'b1);
      full_op("pos_ovf", 8'd127,  8'hFF,   1'b1);
      full_op("neg_ovf", 8'h80,   8'd1,    1'b1);

      // Random back-to-back with edge values first.
      out_ready = 1'b1;
      full_op("m5_m5",   8'hFB,   8'hFB,   1'b0);
      full_op("z_m128",  8'd0,    8'h80,   1'b0);
      full_op("m1_127",  8'hFF,   8'd127,  1'b0);
      full_op("m128_m128", 8'h80, 8'h80,   1'b0);
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         full_op("rand", ra, rb, 1'b0);
      end
      out_ready = 1'b0;

      // Backpressure: result held, stray in_valid ignored.
      start_op(8'd100, 8'hC4);
      wait_done(1'b1, lat);
      check_result("bp", 8'd100, 8'hC4);
      held_d = diff;
      held_o = ovf;
      held_u = uvf;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         in_valid = k[0];
         a        = W'($urandom);
         b        = W'($urandom);
         @(posedge clk);
         #1;
         check("bp_valid_held", 32'(out_valid), 32'd1);
         check("bp_ready_low",  32'(in_ready), 32'd0);
         check("bp_diff_held",  32'(diff), 32'(held_d));
         check("bp_flags_held", 32'({ovf, uvf}), 32'({held_o, held_u}));
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_result();
      check("idle_diff_kept", 32'(diff), 32'(held_d));
      repeat (3) @(posedge clk);
      #1;
      check("idle_stays_idle", 32'(in_ready), 32'd1);

      // Reset in the middle of RUN (cnt = 3 after three RUN edges).
      start_op(8'd77, 8'd33);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_diff",  32'(diff), 32'd0);
      repeat (W + 2) begin
         @(posedge clk);
         #1;
         check("rst_no_valid", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      full_op("after_rst", 8'd10, 8'd20, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
